// File: rtl/eth_rx_crc_check_if.sv
// MII receive stream and frame-status bundle between the MII sync stage and the RX MAC buffer.
// The master drives the MII nibble stream; the slave is the framer/FCS checker.
interface eth_rx_crc_check_if #(
  parameter int unsigned CNT_W = 11
);
  logic             rx_dv;
  logic             rx_er;
  logic [3:0]       rxd;
  logic [7:0]       rx_byte;
  logic             rx_byte_valid;
  logic             frame_start;
  logic             frame_end;
  logic             crc_ok;
  logic             len_err;
  logic             align_err;
  logic             sym_err;
  logic [CNT_W-1:0] byte_cnt;

  modport master (
    output rx_dv, rx_er, rxd,
    input  rx_byte, rx_byte_valid, frame_start, frame_end,
           crc_ok, len_err, align_err, sym_err, byte_cnt
  );

  modport slave (
    input  rx_dv, rx_er, rxd,
    output rx_byte, rx_byte_valid, frame_start, frame_end,
           crc_ok, len_err, align_err, sym_err, byte_cnt
  );
endinterface

// File: rtl/eth_rx_crc_check.sv
// MII receive framer: preamble/SFD detection, nibble-to-byte assembly and CRC-32 FCS check
// with CRC, length, alignment and symbol-error status reported at end of frame.
module eth_rx_crc_check #(
  parameter int unsigned MIN_BYTES = 64,
  parameter int unsigned MAX_BYTES = 1518,
  parameter int unsigned CNT_W     = 11
) (
  input logic             clk,
  input logic             rst_n,
  eth_rx_crc_check_if.slave rx
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [31:0]      CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0]      CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] LEN_MIN     = CNT_W'(MIN_BYTES);
  localparam logic [CNT_W-1:0] LEN_MAX     = CNT_W'(MAX_BYTES);

  state_t           state;
  logic [31:0]      crc;
  logic [31:0]      crc_nxt;
  logic             phase;
  logic [3:0]       low_nib;
  logic             sym_err_int;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       byte_q;
  logic             byte_vld_q;
  logic             start_q;
  logic             end_q;
  logic             crc_ok_q;
  logic             len_err_q;
  logic             align_err_q;
  logic             sym_err_q;

  // Serial CRC unrolled over one nibble, rxd[0] enters first.
  always_comb begin
    crc_nxt = crc;
    for (int unsigned i = 0; i < 4; i++) begin
      crc_nxt = {crc_nxt[30:0], 1'b0} ^ ((crc_nxt[31] ^ rx.rxd[i]) ? CRC_POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      crc         <= '1;
      phase       <= 1'b0;
      low_nib     <= '0;
      sym_err_int <= 1'b0;
      cnt         <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      crc_ok_q    <= 1'b0;
      len_err_q   <= 1'b0;
      align_err_q <= 1'b0;
      sym_err_q   <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (rx.rx_dv) state <= (rx.rxd == 4'h5) ? PREAMBLE : DROP;
        end
        PREAMBLE: begin
          if (!rx.rx_dv) begin
            state <= IDLE;
          end else if (rx.rxd == 4'hD) begin
            state       <= DATA;
            crc         <= '1;
            cnt         <= '0;
            phase       <= 1'b0;
            sym_err_int <= 1'b0;
            start_q     <= 1'b1;
            crc_ok_q    <= 1'b0;
            len_err_q   <= 1'b0;
            align_err_q <= 1'b0;
            sym_err_q   <= 1'b0;
          end else if (rx.rxd != 4'h5) begin
            state <= DROP;
          end
        end
        DATA: begin
          if (rx.rx_dv) begin
            crc   <= crc_nxt;
            phase <= ~phase;
            if (rx.rx_er) sym_err_int <= 1'b1;
            if (!phase) begin
              low_nib <= rx.rxd;
            end else begin
              byte_q     <= {rx.rxd, low_nib};
              byte_vld_q <= 1'b1;
              if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
            end
          end else begin
            // Status is judged on the residue left by the final nibble of the frame.
            state       <= IDLE;
            end_q       <= 1'b1;
            crc_ok_q    <= (crc == CRC_RESIDUE);
            align_err_q <= phase;
            len_err_q   <= (cnt < LEN_MIN) || (cnt > LEN_MAX);
            sym_err_q   <= sym_err_int;
          end
        end
        DROP: begin
          if (!rx.rx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.rx_byte       = byte_q;
  assign rx.rx_byte_valid = byte_vld_q;
  assign rx.frame_start   = start_q;
  assign rx.frame_end     = end_q;
  assign rx.crc_ok        = crc_ok_q;
  assign rx.len_err       = len_err_q;
  assign rx.align_err     = align_err_q;
  assign rx.sym_err       = sym_err_q;
  assign rx.byte_cnt      = cnt;

endmodule

// File: tb/tb_eth_rx_crc_check.sv
// Directed bench for eth_rx_crc_check: known-answer FCS frames, length/alignment/symbol
// boundaries, preamble rejection, minimum IPG and mid-frame reset.
module tb_eth_rx_crc_check;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  eth_rx_crc_check_if #(.CNT_W(11)) bus ();

  eth_rx_crc_check #(
    .MIN_BYTES(64),
    .MAX_BYTES(1518),
    .CNT_W    (11)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  frame[$];
  logic [7:0]  rx_q[$];
  int          fs_cnt;
  int          fe_cnt;
  logic        st_ok, st_len, st_align, st_sym;
  logic [10:0] st_cnt;

  always @(posedge clk) begin
    #1;
    if (bus.rx_byte_valid) rx_q.push_back(bus.rx_byte);
    if (bus.frame_start) fs_cnt++;
    if (bus.frame_end) begin
      fe_cnt++;
      st_ok    = bus.crc_ok;
      st_len   = bus.len_err;
      st_align = bus.align_err;
      st_sym   = bus.sym_err;
      st_cnt   = bus.byte_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    fs_cnt   = 0;
    fe_cnt   = 0;
    st_ok    = 1'bx;
    st_len   = 1'bx;
    st_align = 1'bx;
    st_sym   = 1'bx;
    st_cnt   = 'x;
  endtask

  task automatic drive(input logic dv, input logic [3:0] d, input logic er);
    @(negedge clk);
    bus.rx_dv = dv;
    bus.rxd   = d;
    bus.rx_er = er;
  endtask

  // Sends 15x preamble + SFD + frame[], optional dribble nibble, then one idle cycle.
  task automatic send_frame(input int er_nib, input bit dribble, input int tail);
    logic [7:0] b;
    int k;
    k = 0;
    repeat (15) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < frame.size(); i++) begin
      b = frame[i];
      drive(1'b1, b[3:0], er_nib == k);
      k++;
      drive(1'b1, b[7:4], er_nib == k);
      k++;
    end
    if (dribble) drive(1'b1, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    repeat (tail) @(negedge clk);
  endtask

  // Reference CRC: bits enter LSB-first; FCS is the complemented register sent MSB-first.
  task automatic append_fcs();
    logic [31:0] c;
    logic [7:0]  b;
    c = '1;
    for (int i = 0; i < frame.size(); i++) begin
      b = frame[i];
      for (int j = 0; j < 8; j++) c = {c[30:0], 1'b0} ^ ((c[31] ^ b[j]) ? POLY : 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) b[j] = ~c[31 - 8*k - j];
      frame.push_back(b);
    end
  endtask

  task automatic load_check_frame();
    frame.delete();
    for (int i = 0; i < 9; i++) frame.push_back(8'h31 + 8'(i));
    frame.push_back(8'h26);
    frame.push_back(8'h39);
    frame.push_back(8'hF4);
    frame.push_back(8'hCB);
  endtask

  task automatic load_zero_frame();
    frame.delete();
    repeat (60) frame.push_back(8'h00);
    append_fcs();
  endtask

  task automatic check_bytes(input string tag);
    int nbad;
    nbad = 0;
    check({tag, "_nbytes"}, rx_q.size(), frame.size());
    for (int i = 0; i < rx_q.size() && i < frame.size(); i++)
      if (rx_q[i] !== frame[i]) nbad++;
    check({tag, "_bytes"}, nbad, 0);
  endtask

  task automatic check_status(input string tag, input logic ok, input logic len,
                              input logic align, input logic sym, input int cnt);
    check({tag, "_fs"}, fs_cnt, 1);
    check({tag, "_fe"}, fe_cnt, 1);
    check({tag, "_crc_ok"}, st_ok, ok);
    check({tag, "_len_err"}, st_len, len);
    check({tag, "_align_err"}, st_align, align);
    check({tag, "_sym_err"}, st_sym, sym);
    check({tag, "_byte_cnt"}, st_cnt, cnt);
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.rx_byte, bus.rx_byte_valid, bus.frame_start, bus.frame_end, bus.crc_ok,
            bus.len_err, bus.align_err, bus.sym_err, bus.byte_cnt};
  endfunction

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    rst_n     = 1'b0;
    bus.rx_dv = 1'b0;
    bus.rx_er = 1'b0;
    bus.rxd   = 4'h0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "123456789" with its known FCS
    clear_mon();
    load_check_frame();
    send_frame(-1, 1'b0, 3);
    check_bytes("kat");
    check_status("kat", 1'b1, 1'b1, 1'b0, 1'b0, 13);

    // minimum-length frame of zeros
    clear_mon();
    load_zero_frame();
    send_frame(-1, 1'b0, 3);
    check_bytes("min64");
    check_status("min64", 1'b1, 1'b0, 1'b0, 1'b0, 64);

    // same frame, one payload bit flipped
    clear_mon();
    frame[10] = 8'h04;
    send_frame(-1, 1'b0, 3);
    check_status("bitflip", 1'b0, 1'b0, 1'b0, 1'b0, 64);

    // dribble nibble
    clear_mon();
    load_check_frame();
    send_frame(-1, 1'b1, 3);
    check_bytes("dribble");
    check_status("dribble", 1'b0, 1'b1, 1'b1, 1'b0, 13);

    // bad preamble is dropped, then a clean frame is accepted
    clear_mon();
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h7, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 4'(i), 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("badpre_fs", fs_cnt, 0);
    check("badpre_fe", fe_cnt, 0);
    check("badpre_nbytes", rx_q.size(), 0);
    clear_mon();
    load_check_frame();
    send_frame(-1, 1'b0, 3);
    check_status("after_drop", 1'b1, 1'b1, 1'b0, 1'b0, 13);

    // one-cycle IPG between two frames
    clear_mon();
    send_frame(-1, 1'b0, 0);
    send_frame(-1, 1'b0, 3);
    check("ipg_fs", fs_cnt, 2);
    check("ipg_fe", fe_cnt, 2);
    check("ipg_nbytes", rx_q.size(), 26);
    check("ipg_crc_ok", st_ok, 1'b1);

    // symbol error inside an otherwise good frame
    clear_mon();
    load_zero_frame();
    send_frame(20, 1'b0, 3);
    check_status("symerr", 1'b1, 1'b0, 1'b0, 1'b1, 64);

    // oversize frame saturates the counter
    clear_mon();
    frame.delete();
    for (int i = 0; i < 1600; i++) frame.push_back(8'(i));
    send_frame(-1, 1'b0, 3);
    check("long_nbytes", rx_q.size(), 1600);
    check("long_len_err", st_len, 1'b1);
    check("long_byte_cnt", st_cnt, 1519);

    // rx_dv drops right after SFD
    clear_mon();
    frame.delete();
    send_frame(-1, 1'b0, 3);
    check_status("empty", 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // reset in the middle of DATA
    clear_mon();
    repeat (15) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 4'h3, 1'b0);
    @(negedge clk);
    check("pre_rst_cnt", bus.byte_cnt, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", all_outs(), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    fs_cnt = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, 4'h3, 1'b0);
    check("midrst_cnt_held", bus.byte_cnt, 0);
    drive(1'b0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("midrst_fs", fs_cnt, 0);
    check("midrst_fe", fe_cnt, 0);
    check("midrst_nbytes", rx_q.size(), 0);
    clear_mon();
    load_check_frame();
    send_frame(-1, 1'b0, 3);
    check_status("after_rst", 1'b1, 1'b1, 1'b0, 1'b0, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/eth_rx_crc_check.md
Name: eth_rx_crc_check

Overview:
- MII receive-side framer and FCS checker; the receive counterpart of the nibble-wide CRC-32 generator used on the transmit path.
- Detects preamble/SFD on the 4-bit MII receive stream and assembles nibbles into bytes.
- Runs the CRC-32 over everything after SFD, including the FCS, and reports CRC, length, alignment and symbol status at end of frame.
- Sits between the MII pins (after synchronisation) and the RX MAC buffer.

Parameters:
- MIN_BYTES, 64, minimum legal frame length in bytes (DA through FCS inclusive).
- MAX_BYTES, 1518, maximum legal frame length in bytes (DA through FCS inclusive).
- CNT_W, 11, width of the byte counter; must satisfy 2^CNT_W > MAX_BYTES+1.

Ports:
- clk  input  1  MII receive clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_dv  input  1  MII receive data valid.
- rx_er  input  1  MII receive error.
- rxd  input  4  MII receive nibble; rxd[0] is the first bit on the wire.
- rx_byte  output  8  assembled byte, {second nibble, first nibble}.
- rx_byte_valid  output  1  one-cycle strobe; rx_byte is valid.
- frame_start  output  1  one-cycle pulse after SFD is accepted.
- frame_end  output  1  one-cycle pulse at end of frame; status outputs are valid in the same cycle.
- crc_ok  output  1  final CRC residue equals 0xC704DD7B.
- len_err  output  1  byte count < MIN_BYTES or > MAX_BYTES.
- align_err  output  1  odd number of nibbles after SFD (dribble nibble).
- sym_err  output  1  rx_er was seen while in DATA.
- byte_cnt  output  CNT_W  bytes received in the frame, saturating at MAX_BYTES+1.

Behaviour:
- Reset:
  - All outputs are 0; state = IDLE.
  - CRC register = 0xFFFFFFFF; nibble phase = 0.
  - Asserting rst_n mid-frame aborts the frame with no frame_end. After release the block starts in IDLE; if rx_dv is still high it goes to DROP.
- States: IDLE, PREAMBLE, DATA, DROP. All decisions use the registered inputs sampled on the current edge.
- IDLE:
  - rx_dv=1 and rxd=0x5 -> PREAMBLE.
  - rx_dv=1 with any other rxd -> DROP.
- PREAMBLE:
  - rx_dv=1, rxd=0x5 -> stay.
  - rx_dv=1, rxd=0xD -> DATA. Load CRC = 0xFFFFFFFF, byte_cnt = 0, phase = 0, clear the error flags. frame_start pulses on the next cycle.
  - rx_dv=1 with any other nibble -> DROP.
  - rx_dv=0 -> IDLE, no frame_end.
- DATA, rx_dv=1:
  - Update the CRC with the nibble: for i = 0..3, fb = crc[31] ^ rxd[i]; crc = {crc[30:0],0} ^ (fb ? 0x04C11DB7 : 0).
  - phase 0: store the low nibble, phase <- 1.
  - phase 1: rx_byte <= {rxd, low nibble}, rx_byte_valid pulses on the next cycle, byte_cnt increments (saturating at MAX_BYTES+1), phase <- 0.
  - rx_er=1 sets sym_err_int. The nibble is still processed.
- DATA, rx_dv=0:
  - Go to IDLE and pulse frame_end on the next cycle.
  - crc_ok = (crc == 0xC704DD7B), using the CRC after the final nibble.
  - align_err = phase.
  - len_err from byte_cnt.
  - sym_err from the sticky flag.
  - The status outputs hold their values until the next frame_start.
- DROP: stay until rx_dv=0, then -> IDLE. No outputs are generated.
- Latency: rxd sampled -> rx_byte_valid is 1 cycle after the second nibble edge. frame_end is 1 cycle after rx_dv is sampled low.
- Boundary cases:
  - rx_dv drops immediately after SFD: frame_end pulses; crc_ok=0, len_err=1, byte_cnt=0.
  - Odd nibble count: the dangling nibble is included in the CRC but no byte is emitted; align_err=1.
  - IPG of one cycle (rx_dv low for one cycle) followed by a new preamble is accepted.
  - frame_end and the next frame's activity cannot overlap, because IDLE requires a new preamble.

Test Plan:
- ASCII "123456789" (0x31..0x39) followed by FCS bytes 0x26,0x39,0xF4,0xCB, sent after 15×0x5 + 0xD, low nibble first -> 13 rx_byte_valid strobes with bytes 0x31..0xCB; frame_end with crc_ok=1, len_err=1, align_err=0, byte_cnt=13.
- 60 bytes 0x00 plus a correct FCS from the bench model -> crc_ok=1, len_err=0, byte_cnt=64. The same frame with one payload bit flipped -> crc_ok=0.
- The valid 13-byte frame plus one extra nibble 0x0 before rx_dv falls -> align_err=1, byte_cnt=13, crc_ok=0.
- Preamble 0x5,0x5,0x7 then data -> DROP: no frame_start, no bytes, no frame_end. The next clean frame is received normally.
- rx_er=1 for one data nibble in a correct 64-byte frame -> sym_err=1, crc_ok=1. A 1600-byte frame -> len_err=1 and byte_cnt saturates at 1519.
- rst_n asserted mid-DATA -> all outputs 0 immediately, no frame_end. After release with rx_dv still high -> DROP until rx_dv=0.
